// File: rtl/alu_op_pkg.sv
// Shared ALU opcode definitions used by the encoder and the decoder.
// Also holds the encoder FSM state type and a one-hot helper.
package alu_op_pkg;

  localparam int NUM_OPS = 6;
  localparam int OP_W    = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SLL = 3'd4,
    OP_SRA = 3'd5
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } enc_state_e;

  // Last-granted pointer starts at the top index so opcode 0 has first priority.
  localparam logic [OP_W-1:0] LAST_PTR_RST = OP_W'(NUM_OPS - 1);

  function automatic logic [NUM_OPS-1:0] op_onehot(input logic [OP_W-1:0] op);
    op_onehot = NUM_OPS'(1) << op;
  endfunction

endpackage

// File: rtl/alu_op_encoder_rr_pick.sv
// Combinational round-robin selector: first set bit of vec scanning upward
// from last_ptr+1, wrapping past the top index back to 0.
module rr_pick
  import alu_op_pkg::*;
(
  input  logic [NUM_OPS-1:0] vec,
  input  logic [OP_W-1:0]    last_ptr,
  output logic [OP_W-1:0]    index,
  output logic               any
);

  localparam logic [OP_W:0] NUM_W = (OP_W+1)'(NUM_OPS);

  logic [OP_W:0]   sum;
  logic [OP_W-1:0] cand;

  always_comb begin
    index = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_OPS; i++) begin
      sum = {1'b0, last_ptr} + (OP_W+1)'(i);
      if (sum >= NUM_W) sum = sum - NUM_W;
      cand = sum[OP_W-1:0];
      if (!any && vec[cand]) begin
        any   = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/alu_op_encoder.sv
// Buffers one-hot ALU operation requests, arbitrates round-robin and issues
// the winning opcode on a valid/ready handshake.
module alu_op_encoder
  import alu_op_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_OPS-1:0] req,
  input  logic               op_ready,
  output logic [OP_W-1:0]    opcode,
  output logic               op_valid,
  output logic [NUM_OPS-1:0] pending,
  output logic [CNT_W-1:0]   issued_count
);

  enc_state_e         state, state_n;
  logic [OP_W-1:0]    opcode_n;
  logic [OP_W-1:0]    last_ptr, last_ptr_n;
  logic [CNT_W-1:0]   count_n;
  logic [NUM_OPS-1:0] pending_n;
  logic [NUM_OPS-1:0] clr;
  logic [NUM_OPS-1:0] pick_vec;
  logic [OP_W-1:0]    pick_ptr;
  logic [OP_W-1:0]    pick_idx;
  logic               pick_any;

  rr_pick u_pick (
    .vec      (pick_vec),
    .last_ptr (pick_ptr),
    .index    (pick_idx),
    .any      (pick_any)
  );

  assign op_valid = (state == ST_ISSUE);

  always_comb begin
    state_n    = state;
    opcode_n   = opcode;
    last_ptr_n = last_ptr;
    count_n    = issued_count;
    clr        = '0;
    pick_vec   = pending;
    pick_ptr   = last_ptr;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          opcode_n = pick_idx;
          state_n  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // On handshake the next pick excludes the served bit and uses the
        // just-issued opcode as the round-robin base, enabling back-to-back issue.
        if (op_ready) begin
          clr        = op_onehot(opcode);
          last_ptr_n = opcode;
          count_n    = issued_count + CNT_W'(1);
          pick_vec   = pending & ~clr;
          pick_ptr   = opcode;
          if (pick_any) opcode_n = pick_idx;
          else          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    pending_n = (pending & ~clr) | req;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      opcode       <= OP_ADD;
      last_ptr     <= LAST_PTR_RST;
      issued_count <= '0;
      pending      <= '0;
    end else begin
      state        <= state_n;
      opcode       <= opcode_n;
      last_ptr     <= last_ptr_n;
      issued_count <= count_n;
      pending      <= pending_n;
    end
  end

endmodule

// File: tb/tb_alu_op_encoder.sv
// Self-checking bench for alu_op_encoder: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_alu_op_encoder;

  logic       clock;
  logic       reset;
  logic [5:0] req;
  logic       op_ready;
  logic [2:0] opcode;
  logic       op_valid;
  logic [5:0] pending;
  logic [7:0] issued_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_op_encoder #(.CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .op_ready     (op_ready),
    .opcode       (opcode),
    .op_valid     (op_valid),
    .pending      (pending),
    .issued_count (issued_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [5:0] pend;
    logic       busy;
    logic [2:0] op;
    logic [2:0] last;
    logic [7:0] cnt;
  } mstate_t;

  mstate_t m;
  logic    model_ok = 1'b0;

  function automatic int rr_ref(input logic [5:0] cand, input int base);
    for (int k = 1; k <= 6; k++) begin
      int idx;
      idx = (base + k) % 6;
      if (cand[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic [5:0] rq,
                                         input logic rdy, input logic rst);
    mstate_t    n;
    logic [5:0] cand;
    int         base;
    if (rst) begin
      n.pend = '0; n.busy = 1'b0; n.op = '0; n.last = 3'd5; n.cnt = '0;
      return n;
    end
    n    = s;
    cand = s.pend;
    base = int'(s.last);
    if (s.busy && rdy) begin
      cand[s.op] = 1'b0;
      n.last     = s.op;
      n.cnt      = s.cnt + 8'd1;
      base       = int'(s.op);
    end
    if (!s.busy || rdy) begin
      n.busy = (cand != 6'd0);
      if (cand != 6'd0) n.op = 3'(rr_ref(cand, base));
    end
    n.pend = cand | rq;
    return n;
  endfunction

  always @(posedge clock) begin
    m <= model_next(m, req, op_ready, reset);
    if (reset) model_ok <= 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (model_ok) begin
      chk("model_valid", int'(op_valid), int'(m.busy));
      chk("model_pending", int'(pending), int'(m.pend));
      chk("model_count", int'(issued_count), int'(m.cnt));
      if (m.busy) chk("model_opcode", int'(opcode), int'(m.op));
      if (op_valid) chk("opcode_range", int'(opcode < 3'd6), 1);
    end
  end

  task automatic tick(input logic [5:0] rq, input logic rdy);
    req      = rq;
    op_ready = rdy;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(6'h3F, 1'b1);
    tick(6'h3F, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    req      = 6'h3F;
    op_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_opcode", int'(opcode), 0);
    chk("rst_valid", int'(op_valid), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_count", int'(issued_count), 0);
    reset = 1'b0;

    // single request
    tick(6'b010000, 1'b1);
    chk("single_pend", int'(pending), 6'h10);
    chk("single_lat1", int'(op_valid), 0);
    tick(6'h00, 1'b1);
    chk("single_valid", int'(op_valid), 1);
    chk("single_op", int'(opcode), 4);
    tick(6'h00, 1'b1);
    chk("single_drop", int'(op_valid), 0);
    chk("single_cnt", int'(issued_count), 1);

    // all six from reset priority order
    do_reset();
    tick(6'h3F, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(6'h00, 1'b1);
      chk("burst_valid", int'(op_valid), 1);
      chk("burst_op", int'(opcode), i);
    end
    tick(6'h00, 1'b1);
    chk("burst_end", int'(op_valid), 0);
    chk("burst_cnt", int'(issued_count), 6);

    // back-pressure
    tick(6'b000110, 1'b0);
    tick(6'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(6'h00, 1'b0);
      chk("bp_op", int'(opcode), 1);
      chk("bp_valid", int'(op_valid), 1);
      chk("bp_pend", int'(pending), 6'b000110);
    end
    tick(6'h00, 1'b1);
    chk("bp_next_op", int'(opcode), 2);
    chk("bp_next_valid", int'(op_valid), 1);
    tick(6'h00, 1'b1);
    chk("bp_done", int'(op_valid), 0);

    // re-request in the handshake cycle
    tick(6'b001000, 1'b1);
    tick(6'h00, 1'b1);
    chk("rereq_op1", int'(opcode), 3);
    tick(6'b001000, 1'b1);
    chk("rereq_pend", int'(pending), 6'b001000);
    tick(6'h00, 1'b1);
    chk("rereq_valid2", int'(op_valid), 1);
    chk("rereq_op2", int'(opcode), 3);
    tick(6'h00, 1'b1);
    chk("rereq_clear", int'(pending), 0);

    // reset while issuing
    tick(6'b101000, 1'b0);
    tick(6'h00, 1'b0);
    chk("mid_valid", int'(op_valid), 1);
    reset = 1'b1;
    tick(6'h3F, 1'b1);
    reset = 1'b0;
    chk("mid_rst_valid", int'(op_valid), 0);
    chk("mid_rst_pend", int'(pending), 0);
    chk("mid_rst_cnt", int'(issued_count), 0);
    chk("mid_rst_op", int'(opcode), 0);
    tick(6'h01, 1'b1);
    tick(6'h00, 1'b1);
    chk("post_rst_op", int'(opcode), 0);
    chk("post_rst_valid", int'(op_valid), 1);

    // counter wrap: continuous requests give one handshake per cycle
    do_reset();
    tick(6'h3F, 1'b1);
    tick(6'h3F, 1'b1);
    repeat (256) tick(6'h3F, 1'b1);
    chk("wrap_cnt", int'(issued_count), 0);
    chk("wrap_valid", int'(op_valid), 1);
    tick(6'h3F, 1'b1);
    chk("wrap_cnt1", int'(issued_count), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      tick(6'($urandom) & 6'($urandom), ($urandom_range(0, 3) != 0));
    end
    reset = 1'b0;
    repeat (10) tick(6'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
